riot_bus_arbiter: RTL

- Two-port arbiter and access sequencer for the mm6532 RIOT bus interface.
- Port 0 is the CPU-side requester; port 1 is the debug/host requester.
- Grants one requester at a time and drives the RIOT CS/RS_N/R_W/A/D_IN pins for exactly one access cycle.
- Captures the RIOT D_OUT and returns it to the granted port with a one-cycle ACK.
- Optionally blocks port-1 reads that would clear RIOT interrupt/timer flags.

---
 rtl/riot_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/riot_bus_arbiter.sv
// rtl/riot_bus_arbiter.sv - two-port arbiter and access sequencer for the mm6532 RIOT bus
// Grants one requester, runs a single registered RIOT access, returns data with a one-cycle ACK.

module riot_bus_arbiter #(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int M1_SAFE      = 1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       M0_REQ,
  input  logic       M0_WE,
  input  logic [7:0] M0_ADDR,
  input  logic [7:0] M0_WDATA,
  output logic       M0_ACK,
  output logic [7:0] M0_RDATA,
  input  logic       M1_REQ,
  input  logic       M1_WE,
  input  logic [7:0] M1_ADDR,
  input  logic [7:0] M1_WDATA,
  output logic       M1_ACK,
  output logic [7:0] M1_RDATA,
  output logic       M1_ERR,
  output logic       BUSY,
  output logic [1:0] R_CS,
  output logic       R_RS_N,
  output logic       R_W,
  output logic [6:0] R_A,
  output logic [7:0] R_DIN,
  input  logic [7:0] R_DOUT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       owner;
  logic       op_we;
  logic       op_denied;
  logic       last_grant;
  logic [3:0] starve_cnt;

  logic       grant_valid;
  logic       grant_port;
  logic       grant_we;
  logic [7:0] grant_addr;
  logic [7:0] grant_wdata;
  logic       grant_denied;
  logic       starved;

  assign BUSY = (state != ST_IDLE);

  // Arbitration is evaluated every cycle but only acted on in IDLE.
  always_comb begin
    grant_valid  = M0_REQ | M1_REQ;
    starved      = (STARVE_LIMIT != 0) && (int'(starve_cnt) >= STARVE_LIMIT);
    grant_port   = M1_REQ;
    if (M0_REQ && M1_REQ) begin
      if (PRIO_MODE == 0) begin
        grant_port = ~last_grant;
      end else begin
        grant_port = starved;
      end
    end
    grant_we     = grant_port ? M1_WE    : M0_WE;
    grant_addr   = grant_port ? M1_ADDR  : M0_ADDR;
    grant_wdata  = grant_port ? M1_WDATA : M0_WDATA;
    // Timer and interrupt-flag reads clear RIOT state, so the host port may not do them.
    grant_denied = (M1_SAFE != 0) && grant_port && !grant_we &&
                   grant_addr[7] && grant_addr[2];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      owner      <= 1'b0;
      op_we      <= 1'b0;
      op_denied  <= 1'b0;
      last_grant <= 1'b1;
      starve_cnt <= 4'd0;
      R_CS       <= 2'b00;
      R_RS_N     <= 1'b1;
      R_W        <= 1'b1;
      R_A        <= 7'd0;
      R_DIN      <= 8'd0;
      M0_ACK     <= 1'b0;
      M1_ACK     <= 1'b0;
      M1_ERR     <= 1'b0;
      M0_RDATA   <= 8'd0;
      M1_RDATA   <= 8'd0;
    end else begin
      M0_ACK <= 1'b0;
      M1_ACK <= 1'b0;
      M1_ERR <= 1'b0;
      R_CS   <= 2'b00;
      R_RS_N <= 1'b1;
      R_W    <= 1'b1;
      R_A    <= 7'd0;
      R_DIN  <= 8'd0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_port;
            op_we      <= grant_we;
            op_denied  <= grant_denied;
            last_grant <= grant_port;
            if (!grant_denied) begin
              R_CS   <= 2'b01;
              R_RS_N <= grant_addr[7];
              R_W    <= ~grant_we;
              R_A    <= grant_addr[6:0];
              R_DIN  <= grant_wdata;
            end
          end
          // A pending M1_REQ guarantees a grant this cycle, so grant_port alone decides.
          if (!M1_REQ || grant_port) begin
            starve_cnt <= 4'd0;
          end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ST_ACCESS: begin
          if (owner) begin
            M1_ACK <= 1'b1;
            M1_ERR <= op_denied;
            if (op_denied) begin
              M1_RDATA <= 8'h00;
            end else if (!op_we) begin
              M1_RDATA <= R_DOUT;
            end
          end else begin
            M0_ACK <= 1'b1;
            if (!op_we) begin
              M0_RDATA <= R_DOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
